// File: rtl/arya_pipe_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package arya_pipe_pkg;

  localparam int REG_W_DEF = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the decode instruction reads a register that the
// load currently in execute has not yet written back.
module hazard_detect
  import arya_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_wregen,
  input  logic [REG_W-1:0] ex_wreg,
  output logic             hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare each used source against the pending load destination.
  always_comb begin
    rs1_hit = dec_rs1_used && (dec_rs1 == ex_wreg);
    rs2_hit = dec_rs2_used && (dec_rs2 == ex_wreg);
    hazard  = dec_valid && ex_valid && ex_is_load && ex_wregen && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-stall, flush and load-use handling
// for a fetch/decode/execute pipe, plus a saturating stall counter.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_RUN      | pipeline advancing; execute-stage op has no pending access
//   ST_MEM_WAIT | execute holds a memory op; pipe frozen until mem_ack
module pipe_hazard_ctrl
  import arya_pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [REG_W-1:0] dec_wreg,
  input  logic             dec_wregen,
  input  logic             dec_wmemen,
  input  logic             dec_is_load,
  input  logic             flush,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             fd_en,
  output logic             de_en,
  output logic             de_bubble,
  output logic             fd_flush,
  output logic             mem_req,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state;
  logic             ex_valid;
  logic [REG_W-1:0] ex_wreg;
  logic             ex_wregen;
  logic             ex_is_load;
  logic             ex_mem;
  logic             hazard;
  logic             mem_stall;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_wregen    (ex_wregen),
    .ex_wreg      (ex_wreg),
    .hazard       (hazard)
  );

  // Pipe control by priority: memory stall > flush > load-use > advance.
  // Everything is gated by reset so the outputs drop the instant it asserts.
  always_comb begin
    fd_en     = 1'b0;
    de_en     = 1'b0;
    de_bubble = 1'b0;
    fd_flush  = 1'b0;
    mem_req   = 1'b0;
    if (state == ST_MEM_WAIT) begin
      mem_stall = !mem_ack;
    end else begin
      mem_stall = ex_valid && ex_mem && !mem_ack;
    end
    if (reset) begin
      mem_req = ex_valid && ex_mem;
      if (mem_stall) begin
        fd_en = 1'b0;
        de_en = 1'b0;
      end else if (flush) begin
        fd_en     = 1'b1;
        de_en     = 1'b1;
        de_bubble = 1'b1;
        fd_flush  = 1'b1;
      end else if (hazard) begin
        de_en     = 1'b1;
        de_bubble = 1'b1;
      end else begin
        fd_en = 1'b1;
        de_en = 1'b1;
      end
    end
  end

  // Memory-wait FSM; an ack in MEM_WAIT releases the pipe that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:      if (ex_valid && ex_mem && !mem_ack) state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ack) state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

  // Execute-stage shadow; a bubble empties the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid   <= 1'b0;
      ex_wreg    <= '0;
      ex_wregen  <= 1'b0;
      ex_is_load <= 1'b0;
      ex_mem     <= 1'b0;
    end else if (de_en) begin
      if (de_bubble) begin
        ex_valid   <= 1'b0;
        ex_wreg    <= '0;
        ex_wregen  <= 1'b0;
        ex_is_load <= 1'b0;
        ex_mem     <= 1'b0;
      end else begin
        ex_valid   <= dec_valid;
        ex_wreg    <= dec_wreg;
        ex_wregen  <= dec_wregen;
        ex_is_load <= dec_is_load;
        ex_mem     <= dec_is_load || dec_wmemen;
      end
    end
  end

  // Saturating count of frozen-fetch cycles; clear beats increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (!fd_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 3, register-index width matching WReg1 of the decode/execute pipe.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset: 0 resets immediately regardless of clk.
REQ-005 dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 dec_rs1, dec_rs2  in  REG_W each  source register indices of the decode instruction.
REQ-007 dec_rs1_used, dec_rs2_used  in  1 each  the corresponding source is read.
REQ-008 dec_wreg  in  REG_W  destination index (WReg1_in of the pipe).
REQ-009 dec_wregen, dec_wmemen, dec_is_load  in  1 each  register write, memory write, load.
REQ-010 flush  in  1  branch-redirect request from execute; held by source until pipeline advances.
REQ-011 mem_ack  in  1  memory completes the execute-stage access this cycle.
REQ-012 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-013 fd_en  out  1  enable for fetch/decode pipe register.
REQ-014 de_en  out  1  enable (en) for decode/execute pipe register.
REQ-015 de_bubble  out  1  force WRegEn_in=0 and WMemEn_in=0 into the decode/execute pipe this cycle.
REQ-016 fd_flush  out  1  invalidate the fetch/decode pipe register contents.
REQ-017 mem_req  out  1  execute stage holds a memory op awaiting completion.
REQ-018 stall_cnt  out  CNT_W  count of cycles with fd_en=0.

Function
REQ-019 Block SHALL shadow the execute stage: ex_valid, ex_wreg, ex_wregen, ex_is_load, ex_mem (= load or wmemen), loaded on each cycle de_en=1; bubble loads ex_valid=0.
REQ-020 FSM states RUN and MEM_WAIT; reset state RUN.
REQ-021 mem_req SHALL be 1 when ex_valid=1 and ex_mem=1, in either state, and remain 1 until the cycle mem_ack=1 is seen.
REQ-022 RUN: ex_valid & ex_mem & !mem_ack -> MEM_WAIT, fd_en=de_en=0 that cycle; otherwise remain RUN.
REQ-023 MEM_WAIT: fd_en=de_en=0 while mem_ack=0; mem_ack=1 -> RUN with pipeline advance in the same cycle (zero extra latency).
REQ-024 Load-use hazard = dec_valid & ex_valid & ex_is_load & ex_wregen & ((dec_rs1_used & dec_rs1==ex_wreg) | (dec_rs2_used & dec_rs2==ex_wreg)).
REQ-025 When advancing with hazard: fd_en=0, de_en=1, de_bubble=1 (exactly one bubble per hazard).
REQ-026 When advancing with flush=1: fd_en=1, de_en=1, de_bubble=1, fd_flush=1; load-use hazard ignored that cycle.
REQ-027 Priority: memory stall > flush > load-use hazard > normal advance (fd_en=de_en=1, de_bubble=0, fd_flush=0).
REQ-028 flush during memory stall SHALL have no effect until the stall releases; then applied per REQ-026.
REQ-029 Outputs fd_en, de_en, de_bubble, fd_flush, mem_req SHALL be combinational from state, shadow registers and inputs; no other latency.
REQ-030 stall_cnt SHALL increment by 1 each cycle fd_en=0, saturate at all-ones, and clear to 0 on cnt_clr; cnt_clr wins over a simultaneous increment.
REQ-031 dec_valid=0 SHALL never raise a hazard; an invalid decode slot still advances normally.

Reset
REQ-032 While reset=0: state=RUN, all shadow registers=0, stall_cnt=0; fd_en=de_en=de_bubble=fd_flush=mem_req=0.
REQ-033 Reset asserted mid-MEM_WAIT SHALL abandon the access; after release the first cycle is RUN with fd_en=de_en=1 and mem_req=0.

Structure
REQ-034 Package arya_pipe_pkg SHALL hold the FSM state type, REG_W and CNT_W defaults.
REQ-035 Sub-module hazard_detect SHALL implement the REQ-024 comparator combinationally.

Verification
REQ-036 Load r3 then add using rs1=3 -> one cycle fd_en=0, de_en=1, de_bubble=1; next cycle normal; stall_cnt=1.
REQ-037 Store in execute, mem_ack after 4 cycles -> mem_req=1 for 5 cycles, fd_en=de_en=0 for 4, advance on the ack cycle; stall_cnt=4.
REQ-038 flush=1 coincident with load-use hazard -> fd_flush=1, de_bubble=1, fd_en=1; no hazard stall.
REQ-039 flush=1 during MEM_WAIT, ack on cycle 3 -> flush applied exactly on the ack cycle.
REQ-040 Reset driven low in MEM_WAIT -> outputs 0 asynchronously; after release state RUN, mem_req=0, stall_cnt=0.
REQ-041 Force CNT_W=4, stall 20 cycles -> stall_cnt holds 15; cnt_clr with stall active -> 0.
